// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    localparam int XLEN        = 64;
    localparam int ILEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // A PC is fetchable when it is word aligned and the whole word lies
    // inside the memory (pc_max is the last legal word address).
    function automatic logic pc_fetchable(input logic [XLEN-1:0] pc,
                                          input logic [XLEN-1:0] pc_max);
        return (pc[1:0] == 2'b00) && (pc <= pc_max);
    endfunction

endpackage

// File: rtl/fetch_out_stage.sv
// One-entry output register holding {pc, instr} for the decode stage.
// Handshake: valid stays high and pc/instr stay stable until a cycle in which
// ready is high; the entry is consumed at that rising edge. A load may happen
// in the same cycle the old entry is consumed. Flush drops the entry.
module fetch_out_stage
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            load,
    input  logic            ready,
    input  logic [XLEN-1:0] load_pc,
    input  logic [ILEN-1:0] load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [ILEN-1:0] instr
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;

    // Flush beats load, load beats drain; payload only changes on a load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= load_pc;
            instr_q <= load_instr;
        end else if (ready && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign instr = instr_q;

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, addresses the combinational
// instruction memory and feeds a one-entry output stage towards decode.
// Redirects override everything; halt pauses issue; an unfetchable PC
// parks the controller in FAULT until a redirect or reset.
module instruction_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          IMEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_fault,
    output logic [63:0] fault_pc,
    output logic [1:0]  dbg_state
);

    localparam logic [XLEN-1:0] PC_MAX = XLEN'(IMEM_SIZE - INSTR_BYTES);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(INSTR_BYTES);

    fetch_state_t    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            fault_q;
    logic [XLEN-1:0] fault_pc_q;

    logic pc_ok;
    logic slot_free;
    logic fire;
    logic stage_valid;

    assign pc_ok     = pc_fetchable(pc_q, PC_MAX);
    assign slot_free = !stage_valid || if_ready;
    assign fire      = (state_q == RUN) && !halt && slot_free && pc_ok && !redirect_valid;

    // Next PC: redirect target, sequential advance on a fetch, else hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fire) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Fetch FSM with PC and sticky fault registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                // A redirect in RUN or HALT leaves the state alone; halt
                // is re-evaluated on the following cycle.
                if (state_q == FAULT) begin
                    fault_q <= 1'b0;
                    state_q <= halt ? HALT : RUN;
                end
            end else begin
                unique case (state_q)
                    RUN: begin
                        // Halt is checked first so a pending fault waits
                        // until the controller resumes.
                        if (halt) begin
                            state_q <= HALT;
                        end else if (!pc_ok) begin
                            state_q    <= FAULT;
                            fault_q    <= 1'b1;
                            fault_pc_q <= pc_q;
                        end
                    end
                    HALT: begin
                        if (!halt) begin
                            state_q <= RUN;
                        end
                    end
                    FAULT: begin
                        state_q <= FAULT;
                    end
                    default: begin
                        state_q <= RUN;
                    end
                endcase
            end
        end
    end

    fetch_out_stage u_out_stage (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .load       (fire),
        .ready      (if_ready),
        .load_pc    (pc_q),
        .load_instr (imem_instr),
        .valid      (stage_valid),
        .pc         (if_pc),
        .instr      (if_instr)
    );

    assign imem_addr   = pc_q;
    assign if_valid    = stage_valid;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl with a big-endian combinational memory.
module tb_instruction_fetch_ctrl;

  localparam int IMEM_SIZE = 4096;

  logic        clk;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;
  logic [63:0] fault_pc;
  logic [1:0]  dbg_state;

  int checks;
  int failures;

  logic [95:0] exp_q[$];
  logic [7:0]  mem [IMEM_SIZE];

  instruction_fetch_ctrl #(
    .RESET_PC  (64'h0),
    .IMEM_SIZE (IMEM_SIZE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .fetch_fault    (fetch_fault),
    .fault_pc       (fault_pc),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // image: word 0 = 0x00000013, word i = i * 0x11111111
  function automatic logic [31:0] exp_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0000_0013;
    return 32'(a >> 2) * 32'h1111_1111;
  endfunction

  initial begin
    for (int i = 0; i < IMEM_SIZE / 4; i++) begin
      logic [31:0] w;
      w = exp_word(64'(i * 4));
      mem[i*4]     = w[31:24];
      mem[i*4 + 1] = w[23:16];
      mem[i*4 + 2] = w[15:8];
      mem[i*4 + 3] = w[7:0];
    end
  end

  always_comb begin
    imem_instr = 32'hDEAD_BEEF;
    if (imem_addr <= 64'(IMEM_SIZE - 4))
      imem_instr = {mem[imem_addr[11:0]], mem[imem_addr[11:0] + 12'd1],
                    mem[imem_addr[11:0] + 12'd2], mem[imem_addr[11:0] + 12'd3]};
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] pc);
    exp_q.push_back({pc, exp_word(pc)});
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic redirect(input logic [63:0] pc, input logic h);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    halt           = h;
    cyc();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_fault(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fetch_fault) break;
      cyc();
    end
    chk("fault_wait", 64'(fetch_fault), 64'd1);
  endtask

  // scoreboard monitor: every accepted entry must match the queue head
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL accept_unexpected: got pc 0x%0h instr 0x%0h expected none", if_pc, if_instr);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          failures++;
          $display("FAIL accept: got pc 0x%0h instr 0x%0h expected pc 0x%0h instr 0x%0h",
                   if_pc, if_instr, e[95:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    if_ready       = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'h0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_if_pc", if_pc, 64'h0);
    chk("rst_if_instr", 64'(if_instr), 64'h0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    chk("rst_fault_pc", fault_pc, 64'h0);
    chk("rst_imem_addr", imem_addr, 64'h0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // streaming from reset
    reset = 1'b0;
    push(64'h0); push(64'h4); push(64'h8);
    cyc();
    chk("first_valid", 64'(if_valid), 64'd1);
    chk("first_pc", if_pc, 64'h0);
    cyc();
    chk("stream_pc4", if_pc, 64'h4);
    cyc();
    chk("stream_pc8", if_pc, 64'h8);

    // backpressure
    if_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("bp_pc", if_pc, 64'h8);
      chk("bp_instr", 64'(if_instr), 64'h2222_2222);
      chk("bp_imem_addr", imem_addr, 64'hC);
    end
    if_ready = 1'b1;
    cyc();
    chk("bp_release_pc", if_pc, 64'hC);
    chk("bp_release_instr", 64'(if_instr), 64'h3333_3333);
    if_ready = 1'b0;

    // redirect flush with simultaneous halt
    redirect(64'h100, 1'b1);
    chk("flush_valid", 64'(if_valid), 64'd0);
    chk("flush_imem_addr", imem_addr, 64'h100);
    halt     = 1'b0;
    if_ready = 1'b1;
    push(64'h100);
    cyc();
    chk("redir_valid", 64'(if_valid), 64'd1);
    chk("redir_pc", if_pc, 64'h100);
    halt = 1'b1;
    cyc();
    chk("halt_drain_valid", 64'(if_valid), 64'd0);
    chk("halt_state", 64'(dbg_state), 64'd1);

    // misaligned redirect
    redirect(64'h102, 1'b0);
    wait_fault(8);
    chk("mis_fault_pc", fault_pc, 64'h102);
    chk("mis_state", 64'(dbg_state), 64'd2);
    repeat (3) begin
      cyc();
      chk("mis_valid", 64'(if_valid), 64'd0);
      chk("mis_sticky", 64'(fetch_fault), 64'd1);
    end
    redirect(64'h200, 1'b0);
    chk("clear_fault", 64'(fetch_fault), 64'd0);
    push(64'h200);
    cyc();
    chk("after_fault_pc", if_pc, 64'h200);
    chk("after_fault_valid", 64'(if_valid), 64'd1);
    halt = 1'b1;
    cyc();

    // run off the end of memory
    redirect(64'hFF0, 1'b0);
    push(64'hFF0); push(64'hFF4); push(64'hFF8); push(64'hFFC);
    wait_fault(12);
    chk("range_fault_pc", fault_pc, 64'h1000);
    chk("range_valid", 64'(if_valid), 64'd0);
    chk("range_drained", 64'(exp_q.size()), 64'd0);

    // halt mid-stream
    redirect(64'h40, 1'b0);
    push(64'h40); push(64'h44); push(64'h48); push(64'h4C);
    cyc();
    chk("resume_pc40", if_pc, 64'h40);
    cyc();
    chk("resume_pc44", if_pc, 64'h44);
    cyc();
    chk("resume_pc48", if_pc, 64'h48);
    halt = 1'b1;
    repeat (4) begin
      cyc();
      chk("halt_no_valid", 64'(if_valid), 64'd0);
    end
    halt = 1'b0;
    cyc();
    chk("unhalt_gap", 64'(if_valid), 64'd0);
    cyc();
    chk("unhalt_pc", if_pc, 64'h4C);
    cyc();
    chk("pre_reset_pc", if_pc, 64'h50);

    // reset mid-stream
    reset = 1'b1;
    #1;
    chk("midrst_valid", 64'(if_valid), 64'd0);
    chk("midrst_imem_addr", imem_addr, 64'h0);
    cyc();
    cyc();
    reset = 1'b0;
    push(64'h0); push(64'h4);
    cyc();
    chk("restart_pc0", if_pc, 64'h0);
    chk("restart_valid", 64'(if_valid), 64'd1);
    cyc();
    chk("restart_pc4", if_pc, 64'h4);
    halt = 1'b1;
    cyc();
    cyc();
    chk("final_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
